// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the multiply-accumulate stage.
// Contents: FSM state enum, default widths, counter-width helper.
// Imported by mult_acc_stage_if, mult_acc_add and mult_acc_stage.
package mult_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int P_W_DEF   = 32;
  localparam int ACC_W_DEF = 40;

  // Beat counter width: clog2(vec_len), never below one bit.
  function automatic int cnt_width(input int vec_len);
    cnt_width = (vec_len <= 2) ? 1 : $clog2(vec_len);
  endfunction

endpackage

// File: rtl/mult_acc_stage_if.sv
// Product-in / result-out handshake bundle for mult_acc_stage.
// Ports: p_valid/p_in/p_ready (product beat), acc_valid/acc_out/acc_ready/ovf (result).
// master = upstream+downstream side, slave = the accumulator stage.
interface mult_acc_stage_if
  import mult_acc_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) ();

  logic             p_valid;
  logic [P_W-1:0]   p_in;
  logic             p_ready;
  logic             acc_valid;
  logic [ACC_W-1:0] acc_out;
  logic             acc_ready;
  logic             ovf;

  modport master (
    output p_valid, p_in, acc_ready,
    input  p_ready, acc_valid, acc_out, ovf
  );

  modport slave (
    input  p_valid, p_in, acc_ready,
    output p_ready, acc_valid, acc_out, ovf
  );

endinterface

// File: rtl/mult_acc_add.sv
// Combinational signed adder: acc_i + sext(p_i) at ACC_W bits, with overflow detect.
// Ports: acc_i (accumulator), p_i (product), sum_o (result), ovf_o (signed overflow).
// Macro MULT_ACC_SATURATE_EN: clamp on overflow; otherwise wrap and ovf_o=0.
module mult_acc_add
  import mult_acc_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [P_W-1:0]   p_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] raw_sum;

  assign p_ext   = ACC_W'($signed(p_i));
  assign raw_sum = acc_i + p_ext;

`ifdef MULT_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic a_msb, b_msb, c_in, c_out, ovf;

  assign a_msb = acc_i[ACC_W-1];
  assign b_msb = p_ext[ACC_W-1];
  // Carry into the sign bit falls out of the sign-bit sum; carry out is the
  // full-adder carry of that bit. They differ exactly on signed overflow.
  assign c_in  = a_msb ^ b_msb ^ raw_sum[ACC_W-1];
  assign c_out = (a_msb & b_msb) | (c_in & (a_msb ^ b_msb));
  assign ovf   = c_in ^ c_out;

  // Overflow only happens with equal operand signs, so acc_i's sign picks the rail.
  always_comb begin
    sum_o = raw_sum;
    if (ovf) sum_o = a_msb ? SAT_MIN : SAT_MAX;
  end

  assign ovf_o = ovf;
`else
  assign sum_o = raw_sum;
  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/mult_acc_stage.sv
// Accumulates VEC_LEN signed products into an ACC_W result held on a valid/ready output.
// Ports: clk, rst (sync, active-high), clr (sync abort), bus (slave side of mult_acc_stage_if).
// Latency: result valid the cycle after the last beat; p_ready=0 while holding.
// Macro MULT_ACC_SATURATE_EN selects saturating accumulation with sticky ovf.
module mult_acc_stage
  import mult_acc_pkg::*;
#(
  parameter int P_W     = P_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,  // must be >= P_W
  parameter int VEC_LEN = 16          // 1..65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  mult_acc_stage_if.slave bus
);

  localparam int              CNT_W    = cnt_width(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_valid_q;
  logic             ovf_q;
  logic             add_ovf;
  logic             beat;

  mult_acc_add #(
    .P_W   (P_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i (acc_q),
    .p_i   (bus.p_in),
    .sum_o (acc_d),
    .ovf_o (add_ovf)
  );

  // Held low during reset even though the state already reads ACCUM.
  assign bus.p_ready   = (state_q == ACCUM) && !rst;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;

  assign beat = bus.p_valid && bus.p_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clr) begin
      // A beat offered alongside clr is consumed and thrown away.
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            if (add_ovf) ovf_q <= 1'b1;
            if (cnt_q == CNT_LAST) begin
              acc_out_q   <= acc_d;
              acc_q       <= '0;
              cnt_q       <= '0;
              acc_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            acc_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q     <= ACCUM;
          acc_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
